// File: rtl/bp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_pkg : shared 2-bit counter encodings and constants for branch_predictor|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package bp_pkg;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t SNT = 2'b00;
  localparam bp_cnt_t WNT = 2'b01;
  localparam bp_cnt_t WT  = 2'b10;
  localparam bp_cnt_t ST  = 2'b11;

  localparam bp_cnt_t CNT_RESET = WNT;
  localparam bp_cnt_t CNT_ALLOC = WT;

endpackage
`default_nettype wire

// File: rtl/bp_bht.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_bht : 2-bit saturating counter table, one read and one write port.     |
// | Optional gshare indexing when BP_GSHARE_EN is defined.                    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module bp_bht
  import bp_pkg::*;
#(
  parameter int BHT_IDX_W = 8,
  parameter int GHR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] rd_pc_idx,
  input  logic                 wr_en,
  input  logic [BHT_IDX_W-1:0] wr_pc_idx,
  input  logic                 wr_taken,
  input  logic                 wr_alloc,
  output bp_cnt_t              rd_cnt
);

  localparam int c_DEPTH = 1 << BHT_IDX_W;

  bp_cnt_t              r_cnt [c_DEPTH];
  logic [BHT_IDX_W-1:0] w_rd_idx;
  logic [BHT_IDX_W-1:0] w_wr_idx;
  bp_cnt_t              w_wr_cur;
  bp_cnt_t              w_wr_next;

  if (GHR_W < 1 || GHR_W > BHT_IDX_W) begin : g_ghr_chk
    $error("GHR_W must be in 1..BHT_IDX_W");
  end

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0]     r_ghr;
  logic [BHT_IDX_W-1:0] w_ghr_ext;

  assign w_ghr_ext = BHT_IDX_W'(r_ghr);
  // Update indexes with the history as it was before this branch shifts in.
  assign w_rd_idx  = rd_pc_idx ^ w_ghr_ext;
  assign w_wr_idx  = wr_pc_idx ^ w_ghr_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (wr_en) begin
      r_ghr <= GHR_W'({r_ghr, wr_taken});
    end
  end
`else
  assign w_rd_idx = rd_pc_idx;
  assign w_wr_idx = wr_pc_idx;
`endif

  always_comb begin
    w_wr_cur  = r_cnt[w_wr_idx];
    w_wr_next = w_wr_cur;
    if (wr_alloc) begin
      w_wr_next = CNT_ALLOC;
    end else if (wr_taken) begin
      if (w_wr_cur != ST) w_wr_next = w_wr_cur + 2'd1;
    end else begin
      if (w_wr_cur != SNT) w_wr_next = w_wr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) r_cnt[i] <= CNT_RESET;
    end else if (wr_en) begin
      r_cnt[w_wr_idx] <= w_wr_next;
    end
  end

  assign rd_cnt = r_cnt[w_rd_idx];

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_predictor : direct-mapped BTB plus 2-bit BHT, combinational lookup |
// | from PCF, training from EX. Optional gshare via BP_GSHARE_EN.             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BTB_IDX_W = 6,
  parameter int BHT_IDX_W = 8,
  parameter int GHR_W     = 8
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic        BrInstE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        StallE,
  output logic        isBtbTaken,
  output logic        isBhtTaken,
  output logic [31:0] BtbPCPred
);

  localparam int c_BTB_DEPTH = 1 << BTB_IDX_W;
  localparam int c_TAG_W     = 30 - BTB_IDX_W;

  logic               r_valid  [c_BTB_DEPTH];
  logic [c_TAG_W-1:0] r_tag    [c_BTB_DEPTH];
  logic [31:0]        r_target [c_BTB_DEPTH];

  logic [BTB_IDX_W-1:0] w_rd_idx;
  logic [c_TAG_W-1:0]   w_rd_tag;
  logic                 w_rd_hit;
  logic [BTB_IDX_W-1:0] w_wr_idx;
  logic [c_TAG_W-1:0]   w_wr_tag;
  logic                 w_wr_hit;
  logic                 w_train;
  logic                 w_btb_we;
  logic                 w_alloc;
  bp_cnt_t              w_rd_cnt;
  logic                 w_unused;

  assign w_unused = ^{PCF[1:0], PCE[1:0]};

  assign w_rd_idx = PCF[BTB_IDX_W+1:2];
  assign w_rd_tag = PCF[31:BTB_IDX_W+2];
  assign w_rd_hit = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);

  assign w_wr_idx = PCE[BTB_IDX_W+1:2];
  assign w_wr_tag = PCE[31:BTB_IDX_W+2];
  assign w_wr_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

  assign w_train  = BrInstE && !StallE;
  assign w_btb_we = w_train && BranchE;
  // A taken branch that misses (invalid or foreign tag) takes over the entry.
  assign w_alloc  = w_btb_we && !w_wr_hit;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      for (int i = 0; i < c_BTB_DEPTH; i++) r_valid[i] <= 1'b0;
    end else if (w_btb_we) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST && w_btb_we) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= BranchTarget;
    end
  end

  bp_bht #(
    .BHT_IDX_W (BHT_IDX_W),
    .GHR_W     (GHR_W)
  ) u_bht (
    .clk       (CPU_CLK),
    .rst       (CPU_RST),
    .rd_pc_idx (PCF[BHT_IDX_W+1:2]),
    .wr_en     (w_train),
    .wr_pc_idx (PCE[BHT_IDX_W+1:2]),
    .wr_taken  (BranchE),
    .wr_alloc  (w_alloc),
    .rd_cnt    (w_rd_cnt)
  );

  assign isBtbTaken = w_rd_hit;
  assign isBhtTaken = w_rd_hit && w_rd_cnt[1];
  assign BtbPCPred  = w_rd_hit ? r_target[w_rd_idx] : 32'h0;

endmodule
`default_nettype wire
